// File: rtl/audio_pkg.sv
// Shared types, output limits and the fixed-point to 16-bit saturating conversion.
package audio_pkg;

    typedef enum logic {
        PRIMING = 1'b0,
        RUNNING = 1'b1
    } pacer_state_e;

    localparam logic signed [15:0] SAMPLE_MAX = 16'sh7FFF;
    localparam logic signed [15:0] SAMPLE_MIN = 16'sh8000;

    // Registered per-sample outputs of the pacer.
    typedef struct packed {
        logic               valid;
        logic signed [15:0] sample;
        logic               overflow;
        logic               underflow;
    } pacer_out_t;

    function automatic logic signed [15:0] sat_shift32to16(
        input logic signed [31:0] value,
        input int unsigned        frac_bits
    );
        logic signed [31:0] s;
        s = value >>> frac_bits;
        if (s > 32'sd32767)       return SAMPLE_MAX;
        else if (s < -32'sd32768) return SAMPLE_MIN;
        return s[15:0];
    endfunction

endpackage

// File: rtl/audio_out_pacer_sync_fifo.sv
// Synchronous FIFO with a fall-through head; a push while full only lands if a pop frees a slot.
module sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    output logic [DATA_WIDTH-1:0]      head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic                  do_push, do_pop;

    assign full    = level == LW'(DEPTH);
    assign empty   = level == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    // Storage needs no reset: pointers and level define what is valid.
    always_ff @(posedge clk_in) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/audio_out_pacer.sv
// Buffers bursty PSOLA samples and releases one saturated 16-bit sample per SAMPLE_PERIOD.
// Optional PWM DAC output is built only when AUDIO_OUT_PWM_EN is defined.
module audio_out_pacer
    import audio_pkg::*;
#(
    parameter int SAMPLE_PERIOD = 2304,
    parameter int FIFO_DEPTH    = 16,
    parameter int PRIME_LEVEL   = 8,
    parameter int FRAC_BITS     = 8
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [31:0]                   audio_in,
    input  logic                          audio_valid_in,
    output logic [15:0]                   sample_out,
    output logic                          sample_valid_out,
    output logic                          pwm_out,
    output logic                          overflow_out,
    output logic                          underflow_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_out
);
    localparam int CNT_W = $clog2(SAMPLE_PERIOD);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    if (SAMPLE_PERIOD < 2) begin : g_bad_period
        $error("SAMPLE_PERIOD must be at least 2");
    end
    if (PRIME_LEVEL < 1 || PRIME_LEVEL > FIFO_DEPTH) begin : g_bad_prime
        $error("PRIME_LEVEL must be within 1..FIFO_DEPTH");
    end

    logic [CNT_W-1:0] period_cnt;
    pacer_state_e     state;
    pacer_out_t       out_q;
    logic             tick, pop, drop, underflow, prime_ok;
    logic             fifo_full, fifo_empty;
    logic [31:0]      head;
    logic [LVL_W-1:0] level;

    sync_fifo #(
        .DATA_WIDTH(32),
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .push   (audio_valid_in),
        .pop    (pop),
        .wr_data(audio_in),
        .head   (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (level)
    );

    assign tick      = period_cnt == CNT_W'(SAMPLE_PERIOD - 1);
    assign prime_ok  = level >= LVL_W'(PRIME_LEVEL);
    assign underflow = tick && (state == RUNNING) && fifo_empty;
    // Priming pops on the same tick that flips to RUNNING.
    assign pop       = tick && ((state == RUNNING) ? !fifo_empty : prime_ok);
    assign drop      = audio_valid_in && fifo_full && !pop;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            period_cnt <= '0;
            state      <= PRIMING;
            out_q      <= '0;
        end else begin
            period_cnt      <= tick ? '0 : period_cnt + 1'b1;
            out_q.valid     <= tick;
            out_q.overflow  <= drop;
            out_q.underflow <= underflow;
            if (tick) begin
                out_q.sample <= pop ? sat_shift32to16($signed(head), FRAC_BITS) : '0;
                case (state)
                    PRIMING: if (prime_ok)   state <= RUNNING;
                    RUNNING: if (fifo_empty) state <= PRIMING;
                    default:                 state <= PRIMING;
                endcase
            end
        end
    end

    assign sample_out       = out_q.sample;
    assign sample_valid_out = out_q.valid;
    assign overflow_out     = out_q.overflow;
    assign underflow_out    = out_q.underflow;
    assign fifo_level_out   = level;

`ifdef AUDIO_OUT_PWM_EN
    logic [7:0] pwm_cnt, duty;

    // Duty latches only at the counter wrap so each PWM frame is a single width.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pwm_cnt <= '0;
            duty    <= '0;
            pwm_out <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (pwm_cnt == 8'hFF) duty <= out_q.sample[15:8] ^ 8'h80;
            pwm_out <= pwm_cnt < duty;
        end
    end
`else
    assign pwm_out = 1'b0;
`endif

endmodule
